// File: rtl/sr_drv_pkg.sv
// Shared types for the SR latch drive sequencer: FSM states, command encoding,
// counter width and the request-resolution helper.
package sr_drv_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_SET  = 2'd1,
    CMD_CLR  = 2'd2
  } cmd_t;

  // Simultaneous set/clear collapses to one command; the loser is discarded.
  function automatic cmd_t resolve_req(input logic set_r, input logic clr_r,
                                       input logic set_first);
    cmd_t c;
    c = CMD_NONE;
    if (set_r && clr_r) c = set_first ? CMD_SET : CMD_CLR;
    else if (set_r)     c = CMD_SET;
    else if (clr_r)     c = CMD_CLR;
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/sr_req_slot.sv
// One-entry pending command buffer with a sticky overflow flag.
// A read and a write in the same cycle replace the entry, so the write is never dropped.
import sr_drv_pkg::*;

module sr_req_slot (
  input  logic clk,
  input  logic rst,
  input  logic wr,
  input  cmd_t wr_cmd,
  input  logic rd,
  output cmd_t rd_cmd,
  output logic full,
  output logic overflow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      rd_cmd   <= CMD_NONE;
      overflow <= 1'b0;
    end else begin
      if (wr && (!full || rd)) begin
        full   <= 1'b1;
        rd_cmd <= wr_cmd;
      end else if (rd) begin
        full   <= 1'b0;
        rd_cmd <= CMD_NONE;
      end
      if (wr && full && !rd) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/sr_drive_ctrl.sv
// SR latch drive sequencer: setup, enable strobe, hold, done; one pending request.
// Define SR_READBACK_CHK_EN to build the q_fb readback compare driving err.
import sr_drv_pkg::*;

module sr_drive_ctrl #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned PULSE_W      = 2,
  parameter int unsigned HOLD_CYC     = 1,
  parameter bit          SET_PRIORITY = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic EN,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic err
);

  localparam logic [CNT_W-1:0] SETUP_LD = cnt_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD = cnt_load(PULSE_W);
  localparam logic [CNT_W-1:0] HOLD_LD  = cnt_load(HOLD_CYC);

  state_t           state;
  cmd_t             cmd;
  cmd_t             req_cmd;
  cmd_t             slot_cmd;
  logic [CNT_W-1:0] cnt;
  logic             has_req;
  logic             slot_full;
  logic             slot_rd;
  logic             slot_wr;
  logic             direct_load;
  logic             driving;

  // A queued command is serviced ahead of a new one, which then takes the slot.
  always_comb begin
    req_cmd     = resolve_req(set_req, clr_req, SET_PRIORITY);
    has_req     = (req_cmd != CMD_NONE);
    slot_rd     = slot_full && ((state == IDLE) || (state == DONE));
    direct_load = has_req && (state == IDLE) && !slot_full;
    slot_wr     = has_req && !direct_load;
    driving     = (state == SETUP) || (state == STROBE) || (state == HOLD);
  end

  sr_req_slot u_slot (
    .clk      (CLK),
    .rst      (RESET),
    .wr       (slot_wr),
    .wr_cmd   (req_cmd),
    .rd       (slot_rd),
    .rd_cmd   (slot_cmd),
    .full     (slot_full),
    .overflow (overflow)
  );

  // Outputs are registered decodes of the current state, so the drive pins
  // trail the state register by one cycle and can never glitch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cmd   <= CMD_NONE;
      cnt   <= '0;
      S     <= 1'b0;
      R     <= 1'b0;
      EN    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      S    <= driving && (cmd == CMD_SET);
      R    <= driving && (cmd == CMD_CLR);
      EN   <= (state == STROBE);
      busy <= driving;
      done <= (state == DONE);

      case (state)
        IDLE: begin
          if (slot_rd) begin
            cmd   <= slot_cmd;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end else if (has_req) begin
            cmd   <= req_cmd;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= PULSE_LD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (slot_rd) begin
            cmd   <= slot_cmd;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SR_READBACK_CHK_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err <= 1'b0;
    end else if ((state == DONE) && (q_fb != (cmd == CMD_SET))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Self-checking bench for sr_drive_ctrl: three parameterisations driven in parallel
// against a time-window reference model, plus directed latency/width checks.
module tb_sr_drive_ctrl;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic q_fb   [3];
  logic s_o    [3];
  logic r_o    [3];
  logic en_o   [3];
  logic busy_o [3];
  logic done_o [3];
  logic ovf_o  [3];
  logic err_o  [3];

  int total = 0;
  int bad   = 0;
  int k     = 0;

  int su [3] = '{1, 1, 3};
  int pw [3] = '{2, 2, 1};
  int hc [3] = '{1, 1, 2};
  bit sp [3] = '{1'b0, 1'b1, 1'b0};

  int act_v [3], act_c [3], act_s [3], pend_v [3], pend_c [3];
  bit m_ovf [3], m_err [3];
  logic latch [3];
  logic stuck [3];
  logic [6:0] expv [3];

  always #5 CLK = ~CLK;

  sr_drive_ctrl dut0 (
    .CLK(CLK), .RESET(RESET), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb[0]),
    .S(s_o[0]), .R(r_o[0]), .EN(en_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .overflow(ovf_o[0]), .err(err_o[0]));

  sr_drive_ctrl #(.SET_PRIORITY(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb[1]),
    .S(s_o[1]), .R(r_o[1]), .EN(en_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .overflow(ovf_o[1]), .err(err_o[1]));

  sr_drive_ctrl #(.SETUP_CYC(3), .PULSE_W(1), .HOLD_CYC(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb[2]),
    .S(s_o[2]), .R(r_o[2]), .EN(en_o[2]), .busy(busy_o[2]), .done(done_o[2]),
    .overflow(ovf_o[2]), .err(err_o[2]));

  function automatic logic [6:0] obs(int i);
    return {s_o[i], r_o[i], en_o[i], busy_o[i], done_o[i], ovf_o[i], err_o[i]};
  endfunction

  function automatic int resolve(int i, logic s, logic c);
    if (s && c) return sp[i] ? 1 : 2;
    if (s) return 1;
    if (c) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      act_v[i] = 0; pend_v[i] = 0; m_ovf[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  // One clock edge. A command started at edge s with total end d drives its pins in
  // cycles s+1..d, strobes in s+SU+1..s+SU+PW and pulses done at d+1.
  task automatic tick();
    int   r [3];
    logic q [3];
    for (int i = 0; i < 3; i++) begin
      r[i] = resolve(i, set_req, clr_req);
      q[i] = q_fb[i];
    end
    @(posedge CLK);
    #1;
    k++;
    for (int i = 0; i < 3; i++) begin
      int d;
      bit b, en, dn, idle, dne;
      logic [4:0] lag;
      d    = act_s[i] + su[i] + pw[i] + hc[i];
      b    = (act_v[i] != 0) && (k >= act_s[i] + 1) && (k <= d);
      en   = (act_v[i] != 0) && (k >= act_s[i] + su[i] + 1) && (k <= act_s[i] + su[i] + pw[i]);
      dn   = (act_v[i] != 0) && (k == d + 1);
      lag  = {b && (act_c[i] == 1), b && (act_c[i] == 2), en, b, dn};
      idle = (act_v[i] == 0) || (k - 1 > d);
      dne  = (act_v[i] != 0) && (k - 1 == d);
`ifdef SR_READBACK_CHK_EN
      if (dne && (q[i] !== (act_c[i] == 1))) m_err[i] = 1'b1;
`endif
      if (idle || dne) begin
        if (pend_v[i] != 0) begin
          act_c[i] = pend_c[i]; act_s[i] = k; act_v[i] = 1; pend_v[i] = 0;
          if (r[i] != 0) begin pend_v[i] = 1; pend_c[i] = r[i]; end
        end else if (idle && r[i] != 0) begin
          act_c[i] = r[i]; act_s[i] = k; act_v[i] = 1;
        end else if (r[i] != 0) begin
          pend_v[i] = 1; pend_c[i] = r[i];
        end
      end else if (r[i] != 0) begin
        if (pend_v[i] == 0) begin pend_v[i] = 1; pend_c[i] = r[i]; end
        else m_ovf[i] = 1'b1;
      end
      expv[i] = {lag, m_ovf[i], m_err[i]};
      if (en_o[i]) latch[i] = s_o[i] ? 1'b1 : (r_o[i] ? 1'b0 : latch[i]);
      q_fb[i] = stuck[i] ? 1'b0 : latch[i];
    end
    set_req = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs(i) !== 7'b0) begin
        bad++;
        $display("FAIL reset dut%0d got=%b exp=%b", i, obs(i), 7'b0);
      end
    end
    #3;
    RESET = 1'b0;
    model_clear();
  endtask

  task automatic test_single_set();
    int a, d0, d2, s2, en0, en2;
    d0 = -1; d2 = -1; s2 = 0; en0 = 0; en2 = 0;
    set_req = 1'b1;
    tick();
    a = k;
    for (int n = 0; n < 15; n++) begin
      if (n > 0) tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expv[i]) begin
          bad++;
          $display("FAIL single_set dut%0d edge%0d got=%b exp=%b", i, k, obs(i), expv[i]);
        end
      end
      if (done_o[0] && d0 < 0) d0 = k;
      if (done_o[2] && d2 < 0) d2 = k;
      if (s_o[2]) s2++;
      if (en_o[0]) en0++;
      if (en_o[2]) en2++;
    end
    total++;
    if (d0 !== a + 5) begin bad++; $display("FAIL latency_default got=%0d exp=%0d", d0 - a, 5); end
    total++;
    if (d2 !== a + 7) begin bad++; $display("FAIL latency_long got=%0d exp=%0d", d2 - a, 7); end
    total++;
    if (s2 !== 6) begin bad++; $display("FAIL s_width_long got=%0d exp=%0d", s2, 6); end
    total++;
    if (en2 !== 1) begin bad++; $display("FAIL en_width_long got=%0d exp=%0d", en2, 1); end
    total++;
    if (en0 !== 2) begin bad++; $display("FAIL en_width_default got=%0d exp=%0d", en0, 2); end
    total++;
    if (latch[0] !== 1'b1) begin bad++; $display("FAIL latch_q got=%b exp=%b", latch[0], 1'b1); end
  endtask

  task automatic test_both_req();
    int s0, r0, s1, r1;
    s0 = 0; r0 = 0; s1 = 0; r1 = 0;
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int n = 0; n < 15; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expv[i]) begin
          bad++;
          $display("FAIL both_req dut%0d edge%0d got=%b exp=%b", i, k, obs(i), expv[i]);
        end
      end
      if (s_o[0]) s0++;
      if (r_o[0]) r0++;
      if (s_o[1]) s1++;
      if (r_o[1]) r1++;
    end
    total++;
    if (s0 !== 0 || r0 !== 4) begin bad++; $display("FAIL prio_clear got s=%0d r=%0d exp s=0 r=4", s0, r0); end
    total++;
    if (s1 !== 4 || r1 !== 0) begin bad++; $display("FAIL prio_set got s=%0d r=%0d exp s=4 r=0", s1, r1); end
    total++;
    if (ovf_o[0] !== 1'b0) begin bad++; $display("FAIL both_no_ovf got=%b exp=%b", ovf_o[0], 1'b0); end
  endtask

  task automatic test_back_to_back();
    int a, rr;
    rr = -1;
    for (int n = 0; n < 24; n++) begin
      if (n == 0) set_req = 1'b1;
      if (n == 2) clr_req = 1'b1;
      if (n == 3) set_req = 1'b1;
      tick();
      if (n == 0) a = k;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expv[i]) begin
          bad++;
          $display("FAIL back_to_back dut%0d edge%0d got=%b exp=%b", i, k, obs(i), expv[i]);
        end
      end
      if (r_o[0] && rr < 0) rr = k;
      if (n == 3) begin
        total++;
        if (ovf_o[0] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=%b", ovf_o[0], 1'b1); end
      end
    end
    total++;
    if (rr !== a + 6) begin bad++; $display("FAIL queued_clear_start got=%0d exp=%0d", rr - a, 6); end
    total++;
    if (ovf_o[0] !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", ovf_o[0], 1'b1); end
  endtask

  task automatic test_reset_abort();
    int a, d0, rises;
    logic en_prev;
    d0 = -1; rises = 0;
    set_req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (n == 0) a = k;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expv[i]) begin
          bad++;
          $display("FAIL abort_pre dut%0d edge%0d got=%b exp=%b", i, k, obs(i), expv[i]);
        end
      end
    end
    total++;
    if (en_o[0] !== 1'b1) begin bad++; $display("FAIL abort_in_strobe got=%b exp=%b", en_o[0], 1'b1); end
    #2;
    RESET = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs(i) !== 7'b0) begin
        bad++;
        $display("FAIL abort_async dut%0d got=%b exp=%b", i, obs(i), 7'b0);
      end
    end
    model_clear();
    #2;
    RESET = 1'b0;
    en_prev = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expv[i]) begin
          bad++;
          $display("FAIL abort_quiet dut%0d edge%0d got=%b exp=%b", i, k, obs(i), expv[i]);
        end
      end
      if (en_o[0] && !en_prev) rises++;
      en_prev = en_o[0];
    end
    total++;
    if (rises !== 0) begin bad++; $display("FAIL abort_no_en_rise got=%0d exp=%0d", rises, 0); end
    set_req = 1'b1;
    tick();
    a = k;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done_o[0] && d0 < 0) d0 = k;
    end
    total++;
    if (d0 !== a + 5) begin bad++; $display("FAIL post_reset_latency got=%0d exp=%0d", d0 - a, 5); end
  endtask

  task automatic test_readback();
    stuck[0] = 1'b1;
    q_fb[0]  = 1'b0;
    set_req  = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expv[i]) begin
          bad++;
          $display("FAIL readback dut%0d edge%0d got=%b exp=%b", i, k, obs(i), expv[i]);
        end
      end
    end
    stuck[0] = 1'b0;
    total++;
`ifdef SR_READBACK_CHK_EN
    if (err_o[0] !== 1'b1) begin bad++; $display("FAIL readback_err got=%b exp=%b", err_o[0], 1'b1); end
`else
    if (err_o[0] !== 1'b0) begin bad++; $display("FAIL readback_err got=%b exp=%b", err_o[0], 1'b0); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_req = ($urandom_range(0, 5) == 0);
      clr_req = ($urandom_range(0, 5) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expv[i]) begin
          bad++;
          $display("FAIL random dut%0d edge%0d got=%b exp=%b", i, k, obs(i), expv[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      latch[i] = 1'b0; stuck[i] = 1'b0; q_fb[i] = 1'b0;
      act_s[i] = 0; act_c[i] = 0; pend_c[i] = 0;
    end
    model_clear();
    test_reset();
    test_single_set();
    test_both_req();
    test_back_to_back();
    test_reset_abort();
    test_readback();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

endmodule
